mult_bus_master: RTL
====================

Name: mult_bus_master

Overview:
- Host-side initiator for the gpioemu multiply/popcount peripheral bus (saddress/srd/swr/sdata).
- Accepts one command (A1, A2) over a valid/ready handshake and writes both operands to the peripheral.
- Writes the start register, polls status until done, then reads the product W and the ones count L.
- Returns W, L and the overflow-valid flag on a response handshake.

Parameters:
STROBE_LEN, 1, cycles srd/swr held high per access (min 1)
POLL_GAP, 4, idle cycles between consecutive status reads
POLL_MAX, 255, status reads before timeout (8-bit counter, min 1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept a command
cmd_a1  in  24  first operand
cmd_a2  in  24  second operand
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_w  out  32  product low word
rsp_l  out  24  ones count
rsp_ok  out  1  status bit0 (product fits 32 bits)
rsp_timeout  out  1  poll limit reached, W/L invalid
saddress  out  16  bus address
swr  out  1  write strobe
srd  out  1  read strobe
sdata_out  out  32  write data to peripheral
sdata_in  in  32  read data from peripheral
op_count  out  16  completed responses, wraps 0xFFFF->0

Behaviour:
- Reset (async assert): all outputs 0, strobes low immediately, FSM to IDLE. cmd_ready is 1 from the first clock after deassert.
- Register map: A1=0x037F, A2=0x0388, W=0x0390, L=0x0398, CTRL/STATUS=0x03A0. Operands are zero-extended to 32 bits on sdata_out.
- Bus access of 2+STROBE_LEN cycles:
  - SETUP: address/data driven, strobe low.
  - STROBE: strobe high for STROBE_LEN cycles.
  - HOLD: strobe low, address/data held.
  - Read data is captured from sdata_in at the end of HOLD.
  - swr and srd are never high together. Strobes are registered and glitch-free.
- Between accesses, saddress and sdata_out hold their last values.
- FSM: IDLE -> WR_A1 -> WR_A2 -> WR_GO -> RD_STAT -> (WAIT -> RD_STAT)* -> RD_W -> RD_L -> RESP -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch a1/a2 and move to WR_A1. cmd_ready=0 in all other states.
- WR_GO: writes 0x00000000 to 0x03A0, which starts the operation. The poll counter clears.
- RD_STAT:
  - If status[1]=1 (done, value 2'b11), latch rsp_ok=status[0] and go to RD_W.
  - Otherwise increment the poll counter. If it equals POLL_MAX, set rsp_timeout=1, rsp_w=0, rsp_l=0, and go to RESP (W/L reads skipped).
  - Otherwise go to WAIT for POLL_GAP cycles.
- RD_W captures sdata_in[31:0]. RD_L captures sdata_in[23:0].
- RESP:
  - rsp_valid=1, and rsp_* stay stable until rsp_valid&rsp_ready.
  - On that handshake: op_count+1 (timeouts included), rsp_valid=0, go to IDLE.
  - rsp_ready already high on entry gives a 1-cycle RESP.
- rsp_timeout and rsp_ok clear when the next command is accepted.
- cmd_valid while busy: ignored (not latched). Operands are sampled only on the accept cycle.
- Minimum latency, cmd accept to rsp_valid (STROBE_LEN=1, done on first status read): 6 accesses × 3 = 18 cycles, +1 for RESP entry = 19.
- Reset mid-access: strobe drops at once, and the in-flight command is discarded with no response.

Test Plan:
- Reset held 5 cycles, then released: all outputs 0. cmd_ready=1 on the first clock after release. srd/swr never asserted.
- cmd A1=3, A2=5, behavioural slave done immediately:
  - Write sequence 0x037F←3, 0x0388←5, 0x03A0←0.
  - Then read 0x03A0, 0x0390, 0x0398.
  - Response W=15, L=4, ok=1, timeout=0. rsp_valid rises 19 cycles after accept. op_count=1.
- A1=0xFFFFFF, A2=0xFFFFFF, slave returns status 2'b10 then W=0x00000001, L=1 → rsp_ok=0, W=1, L=1.
- Slave reports 2'b01 for 3 reads, then 2'b11 → exactly 4 status reads, each gap ≥POLL_GAP idle cycles. Correct W/L returned.
- POLL_MAX=3, slave never done → 3 status reads, no W/L reads, rsp_timeout=1, W=0, L=0. op_count increments.
- Backpressure and reset:
  - rsp_ready held low 10 cycles: rsp_* stable, cmd_ready=0, and a second cmd_valid is ignored.
  - reset asserted during the WR_A2 strobe: swr=0 the same cycle, and no response is ever produced.

Source files
------------

// File: rtl/mult_bus_master_if.sv
// Command/response handshakes and gpioemu peripheral bus of mult_bus_master.
// The master modport is the initiator; slave is the host/peripheral side.
interface mult_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_a1;
    logic [23:0] cmd_a2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic        rsp_ok;
    logic        rsp_timeout;
    logic [15:0] saddress;
    logic        swr;
    logic        srd;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;
    logic [15:0] op_count;

    modport master (
        input  cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
        output cmd_ready, rsp_valid, rsp_w, rsp_l, rsp_ok, rsp_timeout,
               saddress, swr, srd, sdata_out, op_count
    );

    modport slave (
        output cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
        input  cmd_ready, rsp_valid, rsp_w, rsp_l, rsp_ok, rsp_timeout,
               saddress, swr, srd, sdata_out, op_count
    );
endinterface

// File: rtl/mult_bus_master.sv
// Host-side initiator for the gpioemu multiply/popcount peripheral: writes
// operands, starts, polls status, reads W and L, returns them on a handshake.
module mult_bus_master #(
    parameter int unsigned STROBE_LEN = 1,
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned POLL_MAX   = 255
) (
    input logic               clk,
    input logic               reset,
    mult_bus_master_if.master bus
);
    localparam int unsigned CNT_W     = 16;
    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_RD_STAT, S_WAIT, S_RD_W, S_RD_L, S_RESP
    } state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    state_t             state_q, state_d, go_st;
    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         poll_q, poll_d, poll_inc;
    logic [23:0]        a2_q, a2_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_w_q, rsp_w_d;
    logic [23:0]        rsp_l_q, rsp_l_d;
    logic               rsp_ok_q, rsp_ok_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic [15:0]        saddr_q, saddr_d;
    logic               swr_q, swr_d, srd_q, srd_d;
    logic [31:0]        sdata_q, sdata_d;
    logic [15:0]        op_count_q, op_count_d;
    logic               is_wr, go;

    function automatic logic [15:0] addr_of(input state_t s);
        case (s)
            S_WR_A1: addr_of = ADDR_A1;
            S_WR_A2: addr_of = ADDR_A2;
            S_RD_W:  addr_of = ADDR_W;
            S_RD_L:  addr_of = ADDR_L;
            default: addr_of = ADDR_CTRL;
        endcase
    endfunction

    assign is_wr = (state_q == S_WR_A1) || (state_q == S_WR_A2) || (state_q == S_WR_GO);

    // Next-state, bus sequencing and response capture
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        poll_d        = poll_q;
        poll_inc      = poll_q + 8'd1;
        a2_d          = a2_q;
        cmd_ready_d   = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_w_d       = rsp_w_q;
        rsp_l_d       = rsp_l_q;
        rsp_ok_d      = rsp_ok_q;
        rsp_timeout_d = rsp_timeout_q;
        saddr_d       = saddr_q;
        sdata_d       = sdata_q;
        swr_d         = 1'b0;
        srd_d         = 1'b0;
        op_count_d    = op_count_q;
        go            = 1'b0;
        go_st         = S_IDLE;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    a2_d          = bus.cmd_a2;
                    sdata_d       = 32'(bus.cmd_a1);
                    rsp_ok_d      = 1'b0;
                    rsp_timeout_d = 1'b0;
                    go            = 1'b1;
                    go_st         = S_WR_A1;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(POLL_GAP - 1)) begin
                    go    = 1'b1;
                    go_st = S_RD_STAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_STROBE;
                        cnt_d   = '0;
                        swr_d   = is_wr;
                        srd_d   = !is_wr;
                    end
                    PH_STROBE: begin
                        if (cnt_q == CNT_W'(STROBE_LEN - 1)) begin
                            phase_d = PH_HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                            swr_d = is_wr;
                            srd_d = !is_wr;
                        end
                    end
                    default: begin
                        // End of HOLD: read data is valid here
                        case (state_q)
                            S_WR_A1: begin go = 1'b1; go_st = S_WR_A2; end
                            S_WR_A2: begin go = 1'b1; go_st = S_WR_GO; end
                            S_WR_GO: begin
                                poll_d = '0;
                                go     = 1'b1;
                                go_st  = S_RD_STAT;
                            end
                            S_RD_STAT: begin
                                if (bus.sdata_in[1]) begin
                                    rsp_ok_d = bus.sdata_in[0];
                                    go       = 1'b1;
                                    go_st    = S_RD_W;
                                end else if (poll_inc == 8'(POLL_MAX)) begin
                                    poll_d        = poll_inc;
                                    rsp_timeout_d = 1'b1;
                                    rsp_w_d       = '0;
                                    rsp_l_d       = '0;
                                    rsp_valid_d   = 1'b1;
                                    state_d       = S_RESP;
                                end else if (POLL_GAP == 0) begin
                                    poll_d = poll_inc;
                                    go     = 1'b1;
                                    go_st  = S_RD_STAT;
                                end else begin
                                    poll_d  = poll_inc;
                                    cnt_d   = '0;
                                    state_d = S_WAIT;
                                end
                            end
                            S_RD_W: begin
                                rsp_w_d = bus.sdata_in;
                                go      = 1'b1;
                                go_st   = S_RD_L;
                            end
                            S_RD_L: begin
                                rsp_l_d     = bus.sdata_in[23:0];
                                rsp_valid_d = 1'b1;
                                state_d     = S_RESP;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                endcase
            end
        endcase

        // Launch the SETUP phase of the next access
        if (go) begin
            state_d     = go_st;
            phase_d     = PH_SETUP;
            saddr_d     = addr_of(go_st);
            cmd_ready_d = 1'b0;
            if (go_st == S_WR_A2) begin
                sdata_d = 32'(a2_q);
            end else if (go_st == S_WR_GO) begin
                sdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            phase_q       <= PH_SETUP;
            cnt_q         <= '0;
            poll_q        <= '0;
            a2_q          <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_w_q       <= '0;
            rsp_l_q       <= '0;
            rsp_ok_q      <= 1'b0;
            rsp_timeout_q <= 1'b0;
            saddr_q       <= '0;
            sdata_q       <= '0;
            swr_q         <= 1'b0;
            srd_q         <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            poll_q        <= poll_d;
            a2_q          <= a2_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_w_q       <= rsp_w_d;
            rsp_l_q       <= rsp_l_d;
            rsp_ok_q      <= rsp_ok_d;
            rsp_timeout_q <= rsp_timeout_d;
            saddr_q       <= saddr_d;
            sdata_q       <= sdata_d;
            swr_q         <= swr_d;
            srd_q         <= srd_d;
            op_count_q    <= op_count_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_w       = rsp_w_q;
    assign bus.rsp_l       = rsp_l_q;
    assign bus.rsp_ok      = rsp_ok_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.saddress    = saddr_q;
    assign bus.sdata_out   = sdata_q;
    assign bus.swr         = swr_q;
    assign bus.srd         = srd_q;
    assign bus.op_count    = op_count_q;
endmodule
